// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state encoding and WIDTH legal range for the serial arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake, operands and registered results
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  modport master (output start, in1, in2, borrow_in, input busy, done, diff, borrow_out, overflow);
  modport slave (input start, in1, in2, borrow_in, output busy, done, diff, borrow_out, overflow);
endinterface

// File: rtl/half_subtractor.sv
// half_subtractor: single-bit a-b difference and borrow
module half_subtractor (
  output logic diff,
  output logic borrow,
  input  logic in1,
  input  logic in2
);
  assign diff   = in1 ^ in2;
  assign borrow = ~in1 & in2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial in1 - in2 - borrow_in, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to drive overflow with signed overflow; otherwise it is tied to 0.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state, state_nx;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-2:0] dr;
  logic [CW-1:0]    cnt;
  logic             bf, d, d1, b1, b2, bo, load, last;
  half_subtractor hs1 (.diff(d1), .borrow(b1), .in1(a[0]), .in2(b[0]));
  half_subtractor hs2 (.diff(d), .borrow(b2), .in1(d1), .in2(bf));
  assign bo = b1 | b2;
  always_comb begin
    load     = (state != SHIFT) && bus.start;
    last     = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    state_nx = load ? SHIFT : (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    bus.busy = state == SHIFT;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // dr keeps the WIDTH-1 most recent difference bits; the final bit joins it on the way into diff
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a              <= '0;
      b              <= '0;
      dr             <= '0;
      bf             <= 1'b0;
      cnt            <= '0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else if (load) begin
      a   <= bus.in1;
      b   <= bus.in2;
      bf  <= bus.borrow_in;
      cnt <= '0;
    end else if (state == SHIFT) begin
      a   <= a >> 1;
      b   <= b >> 1;
      dr  <= (WIDTH-1)'({d, dr} >> 1);
      bf  <= bo;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.diff       <= {d, dr};
        bus.borrow_out <= bo;
      end
    end
`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.overflow <= 1'b0;
    else if (last) bus.overflow <= bf ^ bo;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench; expected results queued on start, checked on done
module tb_serial_subtractor;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
    int           acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0, n_done = 0, n_push = 0;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic bi, int acc);
    exp_t e;
    int s;
    e.diff = x - y - W'(bi);
    e.bo   = {1'b0, x} < ({1'b0, y} + 9'(bi));
    s      = int'($signed(x)) - int'($signed(y)) - int'(bi);
`ifdef SERIAL_SUB_OVF_EN
    e.ovf  = (s < -(2 ** (W - 1))) || (s > 2 ** (W - 1) - 1);
`else
    e.ovf  = 1'b0;
`endif
    e.acc  = acc;
    return e;
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.done) begin
      n_done++;
      check("busy_done_excl", 32'(bus.busy), 0);
      if (q.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        check("diff", 32'(bus.diff), 32'(e.diff));
        check("borrow_out", 32'(bus.borrow_out), 32'(e.bo));
        check("overflow", 32'(bus.overflow), 32'(e.ovf));
        check("latency", 32'(cyc - e.acc), W);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic bi);
    bus.in1       = x;
    bus.in2       = y;
    bus.borrow_in = bi;
    bus.start     = 1'b1;
    q.push_back(model(x, y, bi, cyc + 1));
    n_push++;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_timeout", q.size(), 0);
    tick();
  endtask
  task automatic single(logic [W-1:0] x, logic [W-1:0] y, logic bi);
    send(x, y, bi);
    tick();
    bus.start = 1'b0;
    drain();
  endtask
  task automatic check_zero(string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_diff"}, 32'(bus.diff), 0);
    check({tag, "_borrow"}, 32'(bus.borrow_out), 0);
    check({tag, "_ovf"}, 32'(bus.overflow), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.borrow_in = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    single(8'h35, 8'h12, 1'b0);
    single(8'h12, 8'h35, 1'b0);
    single(8'h00, 8'h00, 1'b1);
    single(8'h80, 8'h01, 1'b0);
    single(8'h7F, 8'hFF, 1'b0);
    single(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) single(8'($urandom), 8'($urandom), 1'($urandom));
    send(8'h5A, 8'h21, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.in1 = 8'hFF;
    bus.in2 = 8'h01;
    bus.borrow_in = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain();
    send(8'hAA, 8'h0F, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    void'(q.pop_back());
    n_push--;
    #1;
    check_zero("midreset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    single(8'hC3, 8'h3C, 1'b1);
    send(8'h10, 8'h01, 1'b0);
    repeat (9) tick();
    send(8'hFF, 8'hFF, 1'b0);
    repeat (9) tick();
    send(8'h01, 8'h02, 1'b0);
    tick();
    bus.start = 1'b0;
    drain();
    check("done_count", n_done, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
